// File: rtl/point_subtraction.sv
// Affine point subtraction R = P - Q over GF(p): negates Q, then performs a chord addition.
// Self-contained: a binary-Euclid inverter and an MSB-first interleaved modular multiplier, both run sequentially.
module point_subtraction #(
  parameter int n = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         busy,
  output logic         done,
  output logic         infinity,
  output logic         error,
  output logic [3:0]   dbg_state
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse with results valid
  // in that cycle, busy covers the accepting edge up to the done edge, and outputs hold afterwards.
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_INV, S_MUL_L, S_MUL_L2, S_SUB_X3, S_MUL_Y3, S_FIN, S_DONE
  } state_t;

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

  state_t state, state_n;

  logic [n-1:0] pr, x1r, y1r, x2r, y2r;
  logic [n-1:0] num, u, v, ia, ic;
  logic [n-1:0] lam, lsq, tmul, x3w;
  logic [n-1:0] ma, mb, acc, dbl, mul_next;
  logic [CW-1:0] cnt;
  logic          mul_run, mul_last;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] a, input logic [n-1:0] b,
                                           input logic [n-1:0] m);
    logic         c;
    logic [n-1:0] s;
    {c, s} = {1'b0, a} + {1'b0, b};
    if (c || s >= m) s = s - m;
    return s;
  endfunction

  // a + m - b wraps modulo 2^n to the correct residue because the true value is below m.
  function automatic logic [n-1:0] mod_sub(input logic [n-1:0] a, input logic [n-1:0] b,
                                           input logic [n-1:0] m);
    if (a >= b) return a - b;
    return a - b + m;
  endfunction

  // (a + m) / 2 for odd a, computed without the extra carry bit since a and m are both odd.
  function automatic logic [n-1:0] mod_half(input logic [n-1:0] a, input logic [n-1:0] m);
    if (a[0]) return (a >> 1) + (m >> 1) + ONE;
    return a >> 1;
  endfunction

  assign dbl      = mod_add(acc, acc, pr);
  assign mul_next = mb[cnt] ? mod_add(dbl, ma, pr) : dbl;
  assign mul_last = mul_run && (cnt == '0);

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_CHECK;
      S_CHECK:  state_n = (x1r == x2r) ? S_DONE : S_INV;
      S_INV:    if (u == ONE || v == ONE) state_n = S_MUL_L;
      S_MUL_L:  if (mul_last) state_n = S_MUL_L2;
      S_MUL_L2: if (mul_last) state_n = S_SUB_X3;
      S_SUB_X3: state_n = S_MUL_Y3;
      S_MUL_Y3: if (mul_last) state_n = S_FIN;
      S_FIN:    state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pr <= '0; x1r <= '0; y1r <= '0; x2r <= '0; y2r <= '0;
      num <= '0; u <= '0; v <= '0; ia <= '0; ic <= '0;
      lam <= '0; lsq <= '0; tmul <= '0; x3w <= '0;
      ma <= '0; mb <= '0; acc <= '0; cnt <= '0; mul_run <= 1'b0;
      x3 <= '0; y3 <= '0; infinity <= 1'b0; error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pr <= p; x1r <= x1; y1r <= y1; x2r <= x2; y2r <= y2;
          x3 <= '0; y3 <= '0; infinity <= 1'b0; error <= 1'b0;
        end
        S_CHECK: begin
          if (x1r == x2r) begin
            if (y1r == y2r) infinity <= 1'b1;
            else            error    <= 1'b1;
          end else begin
            // Subtracting Q adds -Q, so the chord numerator is y1 + y2.
            num <= mod_add(y1r, y2r, pr);
            u   <= mod_sub(x1r, x2r, pr);
            v   <= pr;
            ia  <= ONE;
            ic  <= '0;
          end
        end
        S_INV: begin
          if (u == ONE) begin
            ia <= ia;
          end else if (v == ONE) begin
            ia <= ic;
          end else if (!u[0]) begin
            u  <= u >> 1;
            ia <= mod_half(ia, pr);
          end else if (!v[0]) begin
            v  <= v >> 1;
            ic <= mod_half(ic, pr);
          end else if (u >= v) begin
            u  <= u - v;
            ia <= mod_sub(ia, ic, pr);
          end else begin
            v  <= v - u;
            ic <= mod_sub(ic, ia, pr);
          end
        end
        S_MUL_L, S_MUL_L2, S_MUL_Y3: begin
          if (!mul_run) begin
            mul_run <= 1'b1;
            acc     <= '0;
            cnt     <= CW'(n - 1);
            ma      <= (state == S_MUL_L) ? num : lam;
            case (state)
              S_MUL_L:  mb <= ia;
              S_MUL_L2: mb <= lam;
              default:  mb <= mod_sub(x1r, x3w, pr);
            endcase
          end else begin
            acc <= mul_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              mul_run <= 1'b0;
              case (state)
                S_MUL_L:  lam  <= mul_next;
                S_MUL_L2: lsq  <= mul_next;
                default:  tmul <= mul_next;
              endcase
            end
          end
        end
        S_SUB_X3: x3w <= mod_sub(mod_sub(lsq, x1r, pr), x2r, pr);
        S_FIN: begin
          x3 <= x3w;
          y3 <= mod_sub(tmul, y1r, pr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_subtraction.sv
// Bench for point_subtraction at n=8: vector table, model-checked random vectors, and
// hand-written sequences for reset mid-operation, held start and start during reset.
module tb_point_subtraction;

  localparam int N = 8;
  localparam int W = 2 * N + 2;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [N-1:0] p, x1, y1, x2, y2;
  logic [N-1:0] x3, y3;
  logic         busy, done, infinity, error;
  logic [3:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] p, x1, y1, x2, y2;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t tbl[4];

  point_subtraction #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p(p), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .x3(x3), .y3(y3), .busy(busy), .done(done),
    .infinity(infinity), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic with a brute-force inverse.
  function automatic logic [W-1:0] ref_sub(input int pm, input int a1, input int b1,
                                           input int a2, input int b2);
    int nm, dn, inv, lm, xr, yr;
    logic [W-1:0] r;
    if (a1 == a2) begin
      r = '0;
      if (b1 == b2) r[1] = 1'b1;
      else          r[0] = 1'b1;
      return r;
    end
    nm  = (b1 + b2) % pm;
    dn  = ((a1 - a2) % pm + pm) % pm;
    inv = 0;
    for (int i = 1; i < pm; i++) if ((dn * i) % pm == 1) inv = i;
    lm = (nm * inv) % pm;
    xr = ((lm * lm - a1 - a2) % pm + pm) % pm;
    yr = ((lm * (a1 - xr) - b1) % pm + pm) % pm;
    r  = {xr[N-1:0], yr[N-1:0], 2'b00};
    return r;
  endfunction

  // Scoreboard: every done pulse pops and compares one expected result.
  always @(negedge clk) begin
    if (reset && done) begin
      logic [W-1:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got %0h with empty queue", {x3, y3, infinity, error});
      end else begin
        e = exp_q.pop_front();
        if ({x3, y3, infinity, error} !== e || busy !== 1'b0) begin
          failures++;
          $display("FAIL result: got x3=%0d y3=%0d inf=%0b err=%0b busy=%0b expected x3=%0d y3=%0d inf=%0b err=%0b busy=0",
                   x3, y3, infinity, error, busy, e[W-1:N+2], e[N+1:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] pp, input logic [N-1:0] a1, input logic [N-1:0] b1,
                       input logic [N-1:0] a2, input logic [N-1:0] b2);
    @(negedge clk);
    p = pp; x1 = a1; y1 = b1; x2 = a2; y2 = b2;
    start = 1'b1;
  endtask

  task automatic run_op(input vec_t t);
    int lat;
    logic got;
    logic [N-1:0] hx, hy;
    drive(t.p, t.x1, t.y1, t.x2, t.y2);
    exp_q.push_back(t.exp);
    lat = 0;
    got = 1'b0;
    while (lat < 500 && !got) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      chk("done_timeout", 32'(lat), 32'(-1));
      exp_q.delete();
    end else begin
      if (t.lat > 0) chk("latency", 32'(lat), 32'(t.lat));
      hx = x3; hy = y3;
      @(negedge clk);
      chk("done_one_cycle_and_hold", {done, busy, x3, y3}, {2'b00, hx, hy});
    end
  endtask

  initial begin : main
    vec_t rv;
    int pl[4];
    int pm, s;
    logic got;
    pl = '{23, 251, 197, 13};

    tbl[0] = '{p: 8'd23, x1: 8'd17, y1: 8'd20, x2: 8'd9,  y2: 8'd7,  exp: {8'd3, 8'd10, 2'b00}, lat: 0};
    tbl[1] = '{p: 8'd23, x1: 8'd3,  y1: 8'd10, x2: 8'd17, y2: 8'd20, exp: {8'd9, 8'd16, 2'b00}, lat: 0};
    tbl[2] = '{p: 8'd23, x1: 8'd3,  y1: 8'd10, x2: 8'd3,  y2: 8'd10, exp: {16'd0, 2'b10},       lat: 2};
    tbl[3] = '{p: 8'd23, x1: 8'd3,  y1: 8'd10, x2: 8'd3,  y2: 8'd13, exp: {16'd0, 2'b01},       lat: 2};

    reset = 1'b0; start = 1'b0;
    p = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {x3, y3, busy, done, infinity, error}, '0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) run_op(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      pm = pl[i % 4];
      rv.p  = N'(pm);
      rv.x1 = N'($urandom_range(0, pm - 1));
      rv.y1 = N'($urandom_range(0, pm - 1));
      rv.x2 = (i % 4 == 3) ? rv.x1 : N'($urandom_range(0, pm - 1));
      rv.y2 = (i == 7) ? rv.y1 : N'($urandom_range(0, pm - 1));
      rv.exp = ref_sub(pm, int'(rv.x1), int'(rv.y1), int'(rv.x2), int'(rv.y2));
      rv.lat = (rv.x1 == rv.x2) ? 2 : 0;
      run_op(rv);
    end

    // Reset while the inverter is running discards the operation.
    drive(8'd23, 8'd17, 8'd20, 8'd9, 8'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_inv_before_reset", {28'd0, dbg_state}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    chk("outputs_during_reset", {x3, y3, busy, done, infinity, error}, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("outputs_after_reset", {x3, y3, busy, done, infinity, error}, '0);
    run_op(tbl[0]);

    // start held through a whole run, operands changed after capture.
    s = done_cnt;
    drive(8'd23, 8'd17, 8'd20, 8'd9, 8'd7);
    exp_q.push_back({8'd3, 8'd10, 2'b00});
    @(negedge clk);
    x1 = 8'd5; y1 = 8'd6;
    got = done;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    start = 1'b0;
    chk("held_start_done_seen", {31'd0, got}, 32'd1);
    repeat (3) @(negedge clk);
    chk("held_start_single_done", 32'(done_cnt - s), 32'd1);
    chk("held_start_idle_after", {31'd0, busy}, 32'd0);

    // start coincident with active reset is ignored.
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("start_during_reset_ignored", {27'd0, busy, dbg_state}, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/point_subtraction.md
# point_subtraction

Affine elliptic-curve point subtraction R = P − Q over GF(p) for short-Weierstrass curves. It is the inverse operation of the point-addition engine: internally it negates Q and performs a chord addition. It sits beside point addition in the ECDSA scalar datapath and serves the verification and undo paths, which need P − Q without a separate negation pass. The block is self-contained, with its own bit-serial modular multiplier and binary-Euclid inverter, and is driven by a start/done handshake.

## Interface
- `n`, 256: coordinate and modulus width in bits.
- `clk`  in  1: clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low reset (asserted when 0, sampled on rising `clk`).
- `start`  in  1: one-cycle request; operands captured on the same edge.
- `p`  in  n: odd prime modulus, p ≥ 3.
- `x1`, `y1`  in  n each: minuend P; affine, each coordinate < p.
- `x2`, `y2`  in  n each: subtrahend Q; affine, each coordinate < p.
- `x3`, `y3`  out  n each: result R; held until the next accepted `start`.
- `busy`  out  1: high from the accepting edge until the edge that raises `done`.
- `done`  out  1: one-cycle pulse; results are valid in the same cycle.
- `infinity`  out  1: R is the point at infinity (P == Q); x3 = y3 = 0.
- `error`  out  1: P == −Q, which would need a doubling and is unsupported; x3 = y3 = 0.

## Operation
- **Math:** λ = (y1 + y2)·(x1 − x2)⁻¹ mod p; x3 = λ² − x1 − x2 mod p; y3 = λ·(x1 − x3) − y1 mod p.
- **Modular add/sub:** computed in n+1 bits, then one conditional subtract or add of p. Results are always < p.
- **Negation:** −y2 = p − y2, except −0 = 0.
- **Operand capture:** on `start` while in IDLE, p, x1, y1, x2, y2 are registered. Later input changes are ignored. `start` while `busy` is ignored.
- **FSM states:**
  - IDLE: waits for `start`; → CHECK.
  - CHECK:
    - if x1 == x2 and y1 == y2: set `infinity`; → DONE.
    - else if x1 == x2: set `error`; → DONE.
    - else: register num = y1+y2 mod p and den = x1−x2 mod p; → INV.
  - INV: binary extended Euclid on (den, p) until u == 1 or v == 1. Halving of odd values adds p first and shifts in n+1 bits. → MUL_L.
  - MUL_L: λ = num·inv; → MUL_L2.
  - MUL_L2: λ²; → SUB_X3.
  - SUB_X3: x3 = λ² − x1 − x2, as two sequential modular subtracts in one cycle; → MUL_Y3.
  - MUL_Y3: t = λ·(x1 − x3); → FIN.
  - FIN: y3 = t − y1 mod p; → DONE.
  - DONE: pulse `done`; → IDLE.
- **Multiplier:** MSB-first interleaved. Each step computes acc = 2·acc mod p, then acc = acc + a mod p if the b bit is set. One bit per cycle, n cycles, plus 1 load cycle.
- **Flags:** `infinity` and `error` are cleared on each accepted `start`. They are mutually exclusive and hold with the results. On a normal result both are 0.
- **Reset:** reset at any time, including mid-operation, forces IDLE. All outputs go to 0 and any in-flight result is discarded.

## Timing
- **Reset values:** x3 = y3 = 0; busy = done = infinity = error = 0.
- **Cycle 0** (start edge): capture; `busy` = 1 from cycle 1.
- **Degenerate path:** CHECK in cycle 1, `done` in cycle 2 (latency 2).
- **Normal path:**
  - CHECK: 1 cycle.
  - INV: ≤ 2n+1 cycles, data-dependent.
  - Each of MUL_L, MUL_L2, MUL_Y3: exactly n+1 cycles.
  - SUB_X3, FIN, DONE: 1 cycle each.
  - Worst case ≈ 5n+8 cycles.
- **`done`:** high exactly one cycle, `busy` falls in that same cycle, and a new `start` is accepted in the cycle after `done`.
- **`start` coincident with active reset:** ignored.

## Test plan
- n=8, p=23, curve y²=x³+x+1: P=(17,20), Q=(9,7) → (3,10), infinity=0, error=0, one `done` pulse.
- P=(3,10), Q=(17,20) → (9,16); checks the negative-denominator and wrap paths.
- P=(3,10), Q=(3,10) → infinity=1, x3=y3=0, `done` 2 cycles after `start`.
- P=(3,10), Q=(3,13) → error=1, x3=y3=0, latency 2.
- Pulse reset mid-INV, then start P=(17,20), Q=(9,7): all outputs 0 during and after reset; the second run returns (3,10).
- Hold `start` high for the whole first run of P=(17,20), Q=(9,7):
  - only one `done` appears before the first run completes;
  - changing x1/y1 after capture does not alter the result (3,10);
  - n=256 P-256 known-answer vector matches the software model.
